// File: rtl/tt_um_micro_div_njp_pkg.sv
// Shared types and constants for the micro restoring divider.
// FSM states, operand widths and uio bit positions live here.
package micro_div_pkg;

    localparam int DW   = 8;
    localparam int VW   = 4;
    localparam int ITER = DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int UIO_START = 4;
    localparam int UIO_SEL   = 5;
    localparam int UIO_BUSY  = 6;
    localparam int UIO_DONE  = 7;

    localparam logic [7:0] UIO_OE = 8'b1100_0000;

endpackage

// File: rtl/tt_um_micro_div_njp_if.sv
// Pin-level bundle of the divider tile (everything except clk/rst_n).
// master drives operands/controls, slave is the divider side.
interface tt_um_micro_div_njp_if;
    import micro_div_pkg::*;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/tt_um_micro_div_njp_datapath.sv
// Restoring-division datapath: operands, partial remainder, quotient
// shifter and the result registers shown on uo_out.
module div_datapath
    import micro_div_pkg::*;
#(
    parameter int DW = micro_div_pkg::DW,
    parameter int VW = micro_div_pkg::VW,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic          fin,
    input  logic          fin_dbz,
    input  logic [CW-1:0] cnt,
    input  logic [DW-1:0] dvd_in,
    input  logic [VW-1:0] dvs_in,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rmd,
    output logic          dbz
);

    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   prem_q, prem_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rmd_q, rmd_d;
    logic          dbz_q, dbz_d;

    logic [CW-1:0] bit_idx;
    logic [VW:0]   shifted;
    logic [VW:0]   diff;
    logic          ge;
    logic [VW:0]   prem_nx;
    logic [DW-1:0] acc_nx;
    logic          unused_ok;

    // The remainder never exceeds the divisor, so its top bit is spare.
    assign unused_ok = prem_q[VW];

    // One restoring step: shift in the next dividend bit, MSB first.
    always_comb begin
        bit_idx = CW'(DW - 1) - cnt;
        shifted = {prem_q[VW-1:0], dvd_q[bit_idx]};
        ge      = shifted >= {1'b0, dvs_q};
        diff    = shifted - {1'b0, dvs_q};
        prem_nx = ge ? diff : shifted;
        acc_nx  = {acc_q[DW-2:0], ge};
    end

    // Next-state selection for operands, shifters and results.
    always_comb begin
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        prem_d = prem_q;
        acc_d  = acc_q;
        quot_d = quot_q;
        rmd_d  = rmd_q;
        dbz_d  = dbz_q;
        if (load) begin
            dvd_d  = dvd_in;
            dvs_d  = dvs_in;
            prem_d = '0;
            acc_d  = '0;
        end
        if (step) begin
            prem_d = prem_nx;
            acc_d  = acc_nx;
        end
        if (fin) begin
            quot_d = acc_nx;
            rmd_d  = prem_nx[VW-1:0];
            dbz_d  = 1'b0;
        end
        if (fin_dbz) begin
            quot_d = '1;
            rmd_d  = '1;
            dbz_d  = 1'b1;
        end
    end

    // Datapath registers, cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
            acc_q  <= '0;
            quot_q <= '0;
            rmd_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            prem_q <= prem_d;
            acc_q  <= acc_d;
            quot_q <= quot_d;
            rmd_q  <= rmd_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quot = quot_q;
    assign rmd  = rmd_q;
    assign dbz  = dbz_q;

endmodule

// File: rtl/tt_um_micro_div_njp.sv
// Micro restoring divider tile: FSM, iteration counter and start edge
// detect; arithmetic lives in div_datapath.
module tt_um_micro_div_njp
    import micro_div_pkg::*;
#(
    parameter int DW = micro_div_pkg::DW,
    parameter int VW = micro_div_pkg::VW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_d_q, start_d_d;
    logic          dbz_pend_q, dbz_pend_d;

    logic          start, sel, launch;
    logic          load, step, fin, fin_dbz;
    logic          busy, done;
    logic [DW-1:0] quot;
    logic [VW-1:0] rmd;
    logic          dbz;
    logic          unused_ok;

    assign unused_ok = ^uio_in[7:6];
    assign start     = uio_in[UIO_START];
    assign sel       = uio_in[UIO_SEL];
    assign launch    = ena & start & ~start_d_q & (state_q != CALC);

    // Control: launch, iterate DW times, or detour through a dbz cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        start_d_d  = start_d_q;
        dbz_pend_d = dbz_pend_q;
        load       = 1'b0;
        step       = 1'b0;
        fin        = 1'b0;
        fin_dbz    = 1'b0;
        if (ena) begin
            start_d_d = start;
            unique case (state_q)
                IDLE, DONE: begin
                    if (dbz_pend_q) begin
                        state_d    = DONE;
                        dbz_pend_d = 1'b0;
                        fin_dbz    = 1'b1;
                    end else if (launch) begin
                        load  = 1'b1;
                        cnt_d = '0;
                        if (uio_in[VW-1:0] == '0) begin
                            state_d    = IDLE;
                            dbz_pend_d = 1'b1;
                        end else begin
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d = DONE;
                        fin     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers, cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            start_d_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_d_q  <= start_d_d;
            dbz_pend_q <= dbz_pend_d;
        end
    end

    div_datapath #(
        .DW(DW),
        .VW(VW),
        .CW(CW)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .fin    (fin),
        .fin_dbz(fin_dbz),
        .cnt    (cnt_q),
        .dvd_in (ui_in[DW-1:0]),
        .dvs_in (uio_in[VW-1:0]),
        .quot   (quot),
        .rmd    (rmd),
        .dbz    (dbz)
    );

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

    // Output views; sel only steers the mux.
    always_comb begin
        uo_out = sel ? {dbz, 7'(rmd)} : 8'(quot);
        uio_out = '0;
        uio_out[UIO_BUSY] = busy;
        uio_out[UIO_DONE] = done;
        uio_oe = UIO_OE;
    end

endmodule

// File: tb/tb_tt_um_micro_div_njp.sv
// Bench for the micro divider: per-cycle model compare, directed
// literal cases, then randomized traffic.
module tb_tt_um_micro_div_njp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    tt_um_micro_div_njp_if bus();

    tt_um_micro_div_njp dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (bus.ena),
        .ui_in  (bus.ui_in),
        .uio_in (bus.uio_in),
        .uo_out (bus.uo_out),
        .uio_out(bus.uio_out),
        .uio_oe (bus.uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Behavioural model: cycles of work left, pending dbz, last result.
    bit m_prev = 0;
    int m_left = 0;
    bit m_pend = 0;
    bit m_done = 0;
    int m_a = 0, m_b = 0;
    int m_q = 0, m_r = 0;
    bit m_dbz = 0;

    always @(posedge clk or negedge rst_n) begin
        bit st;
        bit launch;
        if (!rst_n) begin
            m_prev = 0; m_left = 0; m_pend = 0; m_done = 0;
            m_a = 0; m_b = 0; m_q = 0; m_r = 0; m_dbz = 0;
        end else if (bus.ena) begin
            st = bus.uio_in[4];
            launch = st && !m_prev && m_left == 0;
            m_prev = st;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_q = m_a / m_b;
                    m_r = m_a % m_b;
                    m_dbz = 0;
                end
            end else if (m_pend) begin
                m_pend = 0;
                m_done = 1;
                m_q = 255; m_r = 15; m_dbz = 1;
            end else if (launch) begin
                m_a = int'(bus.ui_in);
                m_b = int'(bus.uio_in[3:0]);
                m_done = 0;
                if (m_b == 0) m_pend = 1;
                else m_left = 8;
            end
        end
    end

    // Every cycle, outputs must match the model.
    always @(negedge clk) begin
        logic [7:0] e_uo, e_uio;
        e_uo = bus.uio_in[5] ? {m_dbz, 3'b000, 4'(m_r)} : 8'(m_q);
        e_uio = {m_done, m_left > 0, 6'b0};
        check("uo_out", int'(bus.uo_out), int'(e_uo));
        check("uio_out", int'(bus.uio_out), int'(e_uio));
        check("uio_oe", int'(bus.uio_oe), 'hC0);
    end

    task automatic drive(input logic [7:0] a, input logic [3:0] b,
                         input logic st);
        bus.ui_in  = a;
        bus.uio_in = {2'b00, 1'b0, st, b};
    endtask

    task automatic wait_done(input int stall_at, output int n,
                             output int nb, output bit got);
        int  hold = 0;
        bit  stalled = 0;
        n = 0; nb = 0; got = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.uio_out[6]) nb++;
            if (bus.uio_out[7]) got = 1;
            else if (stall_at > 0) begin
                if (!stalled && nb == stall_at) begin
                    bus.ena = 0; hold = 3; stalled = 1;
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) bus.ena = 1;
                end
            end
        end
    endtask

    task automatic view_check(input string name, input int q, input int rv);
        bus.uio_in[5] = 0; #1;
        check({name, "_q"}, int'(bus.uo_out), q);
        bus.uio_in[5] = 1; #1;
        check({name, "_rv"}, int'(bus.uo_out), rv);
        bus.uio_in[5] = 0;
    endtask

    task automatic run_op(input string name, input int a, input int b,
                          input int stall, input int en, input int enb,
                          input int q, input int rv);
        int n, nb;
        bit got;
        @(posedge clk); #2;
        drive(8'(a), 4'(b), 1'b1);
        @(posedge clk); #2;
        bus.uio_in[4] = 0;
        wait_done(stall, n, nb, got);
        check({name, "_done"}, int'(got), 1);
        check({name, "_lat"}, n, en);
        check({name, "_busy"}, nb, enb);
        view_check(name, q, rv);
    endtask

    initial begin
        int n, nb;
        bit got;
        bus.ena = 1;
        drive(8'h00, 4'h0, 1'b0);
        #3;
        check("rst_uo", int'(bus.uo_out), 0);
        check("rst_uio", int'(bus.uio_out), 0);
        check("rst_oe", int'(bus.uio_oe), 'hC0);
        @(posedge clk); #2;
        rst_n = 1;

        run_op("d200_7", 200, 7, 0, 9, 8, 'h1C, 'h04);
        run_op("d255_1", 255, 1, 0, 9, 8, 'hFF, 'h00);
        run_op("d5_9", 5, 9, 0, 9, 8, 'h00, 'h05);
        run_op("dbz", 'h2A, 0, 0, 2, 0, 'hFF, 'h8F);

        @(posedge clk); #2;
        drive(8'd77, 4'd5, 1'b1);
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.uio_out[6]) nb++;
        end
        check("held_busy", nb, 8);
        check("held_done", int'(bus.uio_out[7]), 1);
        view_check("held", 'h0F, 'h02);
        @(posedge clk); #2;
        bus.uio_in[4] = 0;

        @(posedge clk); #2;
        drive(8'd100, 4'd7, 1'b1);
        @(posedge clk); #2;
        bus.uio_in[4] = 0;
        repeat (2) @(posedge clk);
        #2;
        drive(8'd50, 4'd3, 1'b1);
        @(posedge clk); #2;
        bus.uio_in[4] = 0;
        wait_done(0, n, nb, got);
        check("ign_done", int'(got), 1);
        check("ign_busy", nb, 5);
        view_check("ign", 'h0E, 'h02);
        repeat (5) @(negedge clk);
        check("persist_done", int'(bus.uio_out[7]), 1);
        view_check("persist", 'h0E, 'h02);

        @(posedge clk); #2;
        drive(8'd200, 4'd7, 1'b1);
        @(posedge clk); #2;
        bus.uio_in[4] = 0;
        repeat (4) @(negedge clk);
        check("mid_busy", int'(bus.uio_out[6]), 1);
        check("mid_prev", int'(bus.uo_out), 'h0E);
        #1 rst_n = 0;
        #1;
        check("arst_uio", int'(bus.uio_out), 0);
        view_check("arst", 0, 0);
        @(posedge clk); #2;
        rst_n = 1;
        run_op("d100_3", 100, 3, 0, 9, 8, 'h21, 'h01);

        run_op("stall", 150, 11, 3, 12, 11, 'h0D, 'h07);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            rst_n = ($urandom_range(0, 199) != 0);
            bus.ena = ($urandom_range(0, 9) != 0);
            bus.ui_in = 8'($urandom);
            bus.uio_in = 8'($urandom);
            bus.uio_in[4] = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk); #2;
        rst_n = 1;
        bus.ena = 1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_micro_div_njp.md
TT_UM_MICRO_DIV_NJP -- requirements
Module: tt_um_micro_div_njp

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning dividend/quotient width.
REQ-002 The block SHALL have parameter VW, default 4, meaning divisor/remainder width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port ena  input  1  enable; when low, FSM, counter and all registers hold.
REQ-006 The block SHALL have port ui_in  input  8  dividend.
REQ-007 The block SHALL have port uio_in  input  8  [3:0] divisor, [4] start, [5] sel (0 quotient view, 1 remainder view), [7:6] ignored.
REQ-008 The block SHALL have port uo_out  output  8  result view selected by sel.
REQ-009 The block SHALL have port uio_out  output  8  [6] busy, [7] done, [5:0] = 0.
REQ-010 The block SHALL have port uio_oe  output  8  constant 8'b1100_0000.

Function
REQ-011 The block SHALL compute unsigned dividend / divisor by restoring division, one quotient bit per cycle, MSB first.
REQ-012 The block SHALL register start into start_d each enabled cycle; a launch SHALL occur only on start & ~start_d.
REQ-013 The FSM SHALL have states IDLE, CALC, DONE.
REQ-014 A launch in IDLE or DONE at edge k SHALL capture dividend and divisor, clear done, and enter CALC (count = 0) or, if divisor = 0, enter DONE at edge k+1.
REQ-015 A launch while in CALC SHALL be ignored; captured operands SHALL NOT change during CALC.
REQ-016 Each CALC cycle SHALL shift the partial remainder (VW+1 bits) left, bring in the next dividend bit, subtract the divisor when the difference is non-negative, and set the quotient bit to 1 in that case, otherwise 0.
REQ-017 After exactly DW CALC cycles (edges k+1..k+8) the FSM SHALL enter DONE, load the quotient and remainder result registers, and assert done at edge k+8.
REQ-018 busy SHALL be high exactly while the state is CALC; done SHALL be high exactly while the state is DONE.
REQ-019 The result registers SHALL update only on entry to DONE; during CALC, uo_out SHALL show the previous result.
REQ-020 The quotient view SHALL be uo_out = quotient[7:0]; the remainder view SHALL be uo_out = {dbz, 3'b000, remainder[3:0]}.
REQ-021 Divide-by-zero SHALL produce quotient 8'hFF, remainder 4'hF, and dbz = 1; a normal result SHALL clear dbz.
REQ-022 sel SHALL be combinational on uo_out and SHALL NOT affect computation.
REQ-023 DONE SHALL persist until the next launch.

Reset
REQ-024 While rst_n is low, the block SHALL be asynchronously forced to state IDLE, with count, start_d, operands, quotient, remainder, dbz, busy and done all 0, and uo_out = 0.
REQ-025 Reset mid-CALC SHALL abort the operation without producing a result; the first launch after release SHALL behave as from power-up.

Structure
REQ-026 Package micro_div_pkg SHALL hold the state enum (IDLE/CALC/DONE), DW, VW, ITER = DW, and the uio bit-index constants.
REQ-027 The block SHALL contain one sub-module, div_datapath, which owns the operand, partial-remainder and quotient shift registers, the subtractor and the result registers; the top SHALL hold the FSM, counter and edge detect.

Verification
REQ-028 The bench SHALL cover: dividend 200, divisor 7, start pulse -> busy for 8 cycles, then done; sel=0 gives 0x1C, sel=1 gives 0x04.
REQ-029 The bench SHALL cover: dividend 255, divisor 1 -> 0xFF, remainder view 0x00; dividend 5, divisor 9 -> quotient 0x00, remainder view 0x05.
REQ-030 The bench SHALL cover: dividend 0x2A, divisor 0 -> done one cycle after launch with busy never high; quotient view 0xFF, remainder view 0x8F.
REQ-031 The bench SHALL cover: start held high for 20 cycles -> exactly one operation; a second rising edge during CALC with new operands -> ignored, result from the first operands.
REQ-032 The bench SHALL cover: rst_n low at CALC cycle 4 -> all outputs 0 immediately; a subsequent 100/3 launch -> 0x21, remainder view 0x01.
REQ-033 The bench SHALL cover: ena low for 3 cycles mid-CALC -> completion delayed by exactly 3 cycles with a correct result.
